// File: rtl/intr_ctrl_pkg.sv
// intr_ctrl_pkg: register map, FSM states and the "no interrupt" claim ID
package intr_ctrl_pkg;
  localparam logic [3:0] ADDR_ENABLE = 4'h0;
  localparam logic [3:0] ADDR_PENDING = 4'h4;
  localparam logic [3:0] ADDR_CLAIM = 4'h8;
  localparam int ID_NONE = 0;
  typedef enum logic {IDLE, SERVICE} intr_state_t;
endpackage

// File: rtl/intr_prio_enc.sv
// intr_prio_enc: fixed-priority encoder, lowest set bit i reports ID i+1, empty reports 0
module intr_prio_enc #(
  parameter int NUM_SRC = 4,
  parameter int ID_W = $clog2(NUM_SRC + 1)
) (
  input logic [NUM_SRC-1:0] vec,
  output logic [ID_W-1:0] id
);
  always_comb begin
    id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (vec[i]) id = ID_W'(i + 1);
  end
endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl: pending/enable interrupt controller with MMIO claim/complete handshake.
// Define INTR_EDGE_DETECT_EN to pend on rising edges of src_intr instead of levels.
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int ID_W = $clog2(NUM_SRC + 1)
) (
  input logic clk,
  input logic rst,
  input logic [NUM_SRC-1:0] src_intr,
  input logic reg_wr,
  input logic reg_rd,
  input logic [3:0] reg_addr,
  input logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic irq,
  output logic busy
);
  intr_state_t state;
  logic [NUM_SRC-1:0] enable, pending, masked, set, clr;
  logic [ID_W-1:0] id, claimed_id;
  logic claim, complete, unused;
  logic [31:0] rdata_nx;
  assign masked = pending & enable;
  intr_prio_enc #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) u_enc (.vec(masked), .id(id));
`ifdef INTR_EDGE_DETECT_EN
  logic [NUM_SRC-1:0] src_intr_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) src_intr_d <= '0;
    else src_intr_d <= src_intr;
  assign set = src_intr & ~src_intr_d;
`else
  assign set = src_intr;
`endif
  assign claim = reg_rd && reg_addr == ADDR_CLAIM && state == IDLE && id != ID_W'(ID_NONE);
  assign complete = reg_wr && reg_addr == ADDR_CLAIM && state == SERVICE && reg_wdata[ID_W-1:0] == claimed_id;
  assign clr = claim ? NUM_SRC'(1) << (id - 1'b1) : '0;
  assign busy = state == SERVICE;
  assign unused = ^reg_wdata[31:NUM_SRC];
  always_comb
    rdata_nx = reg_addr == ADDR_ENABLE ? {{(32-NUM_SRC){1'b0}}, enable} :
               reg_addr == ADDR_PENDING ? {{(32-NUM_SRC){1'b0}}, pending} :
               reg_addr == ADDR_CLAIM ? 32'(state == IDLE ? id : claimed_id) : 32'd0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      enable <= '0;
      pending <= '0;
      claimed_id <= '0;
      irq <= 1'b0;
      reg_rdata <= '0;
    end else begin
      pending <= (pending & ~clr) | set;
      if (reg_wr && reg_addr == ADDR_ENABLE) enable <= reg_wdata[NUM_SRC-1:0];
      if (reg_rd) reg_rdata <= rdata_nx;
      irq <= state == IDLE && |masked;
      if (claim) begin
        state <= SERVICE;
        claimed_id <= id;
      end else if (complete) begin
        state <= IDLE;
        claimed_id <= '0;
      end
    end
  end
endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Small interrupt controller that sits between accelerator-side interrupt sources and the CPU interrupt line.
- Sources include conv-layer done, DMA done and output-buffer full.
- Latches per-source pending bits and masks them with an enable register.
- Picks the highest-priority source (fixed, lowest index wins) and runs a claim/complete handshake with the CPU over a simple MMIO register port.

Parameters:
- NUM_SRC, 4, number of interrupt sources (1..31).
- ID_W, $clog2(NUM_SRC+1), width of the claim ID. ID 0 means "none"; source i reports ID i+1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- src_intr  in  NUM_SRC  raw interrupt requests from sources
- reg_wr  in  1  register write strobe
- reg_rd  in  1  register read strobe
- reg_addr  in  4  byte address: 0x0 ENABLE, 0x4 PENDING, 0x8 CLAIM
- reg_wdata  in  32  write data
- reg_rdata  out  32  read data, valid the cycle after reg_rd
- irq  out  1  interrupt request to the CPU, registered
- busy  out  1  high while a claimed interrupt is in service

Behaviour:
- Reset: enable=0, pending=0, state=IDLE, claimed_id=0, irq=0, busy=0, reg_rdata=0. Reset mid-service drops the claim with no completion required.
- Pending set:
  - Default build: bit i is set every cycle src_intr[i]=1 (level).
  - Setting has priority over a same-cycle clear, so a level source stays pending until it deasserts.
  - Pending bits latch regardless of enable.
- ENABLE (0x0): RW. Bits [NUM_SRC-1:0] are meaningful; upper bits write-ignored and read 0.
- PENDING (0x4): RO. Writes are ignored.
- CLAIM (0x8), read in IDLE:
  - Returns the ID of the lowest-index bit of (pending & enable), or 0 if none.
  - If the ID is nonzero: clear that pending bit, store claimed_id, go to SERVICE.
  - If the ID is 0: remain IDLE.
- CLAIM read in SERVICE: returns claimed_id again. No state change; pending is not cleared.
- CLAIM write (complete):
  - In SERVICE, if reg_wdata[ID_W-1:0]==claimed_id: go to IDLE and clear claimed_id.
  - A mismatched ID, or any write in IDLE, is ignored.
- State machine has two states:
  - IDLE -> SERVICE on a successful claim.
  - SERVICE -> IDLE on a matching complete.
  - busy = (state==SERVICE).
- irq:
  - Registered as (state==IDLE) && |(pending & enable), so it lags by 1 cycle.
  - Deasserts the cycle after a successful claim.
  - Reasserts 1 cycle after completion if anything is still pending and enabled.
- Other addresses: read 0, writes ignored.
- Simultaneous reg_rd and reg_wr: the read returns the pre-write value; the write takes effect the same edge. A CLAIM read plus CLAIM write in the same cycle in IDLE performs the claim only.
- reg_rdata holds its last value when reg_rd=0.

Optional Feature:
- Macro INTR_EDGE_DETECT_EN.
- Defined:
  - A src_intr_d register is added (reset 0).
  - Pending bit i is set only on a rising edge (src_intr[i] & ~src_intr_d[i]).
  - A held-high source pends once per edge.
  - A claim clears the bit unless a new edge arrives in the same cycle.
- Undefined: level behaviour as above; no edge register exists.

Decomposition:
- Package intr_ctrl_pkg holds:
  - address constants ADDR_ENABLE=4'h0, ADDR_PENDING=4'h4, ADDR_CLAIM=4'h8;
  - typedef enum logic {IDLE, SERVICE} intr_state_t;
  - the ID-none constant 0.
- One sub-module, intr_prio_enc (NUM_SRC-bit vector in, ID_W ID out, 0 if empty), is natural.
- The register decode and FSM stay in intr_ctrl.

Test Plan:
- Reset then idle: with src_intr=4'b1010 and enable=0, irq stays 0; PENDING read returns 0xA.
- Write ENABLE=0xF with src_intr pulse 4'b0100 (level build, deasserted before claim): irq=1 two cycles later. CLAIM read returns 3, PENDING bit2 clears, irq=0 next cycle, busy=1.
- Priority: sources 1 and 3 pending, ENABLE=0xF. CLAIM returns 2. Complete with 2 -> irq reasserts 1 cycle later. CLAIM returns 4.
- Wrong complete: in SERVICE with claimed_id=2, write CLAIM=3 -> busy stays 1, irq stays 0. Write 2 -> busy=0.
- Reset mid-service: assert rst while busy=1 -> busy=0, irq=0, enable=0 immediately (asynchronous).
- INTR_EDGE_DETECT_EN: hold src_intr[0]=1 for 10 cycles -> pends once. CLAIM returns 1, then a second CLAIM after complete returns 0.
